demultiplexer_16bit: RTL and testbench
======================================

DEMULTIPLEXER_16BIT -- requirements
Module: demultiplexer_16bit

Interface
REQ-001 Parameter: DW, default 16, data word width in bits; all data ports SHALL use DW.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_data  input  DW  word to be routed.
REQ-005 in_sel  input  4  destination channel 0..15.
REQ-006 in_bcast  input  1  1 = write in_data to all 16 channels; in_sel is ignored.
REQ-007 in_valid  input  1  in_data/in_sel/in_bcast are valid.
REQ-008 in_ready  output  1  the block accepts the word this cycle.
REQ-009 O0..O15  output  DW each  per-channel holding registers.
REQ-010 out_valid  output  16  bit k = O<k> holds an unconsumed word.
REQ-011 out_ready  input  16  bit k = sink k consumes O<k> this cycle.
REQ-012 xfer_count  output  16  count of accepted input transfers, saturating.

Function
REQ-013 Channel k SHALL be free when out_valid[k]=0 or out_ready[k]=1 (drain and refill in the same cycle).
REQ-014 in_ready SHALL be combinational: with in_bcast=0, in_ready = channel in_sel is free; with in_bcast=1, in_ready = all 16 channels are free.
REQ-015 in_ready SHALL NOT depend on in_valid.
REQ-016 Accept = in_valid & in_ready; on accept, the targeted channel(s) SHALL load in_data into O<k> and set out_valid[k]=1 on the same edge (latency 1 cycle).
REQ-017 Channel k SHALL drain when out_valid[k]=1 and out_ready[k]=1; with no simultaneous load, out_valid[k] SHALL clear on that edge.
REQ-018 Simultaneous drain and load on channel k SHALL leave out_valid[k]=1 with O<k> = the new word; no word is lost or duplicated.
REQ-019 out_ready[k] while out_valid[k]=0 SHALL have no effect.
REQ-020 O<k> SHALL hold its value while out_valid[k]=1 and no drain occurs, and SHALL also hold after a drain (not cleared).
REQ-021 Channels not targeted SHALL be unaffected by an accept, except through their own drain.
REQ-022 Broadcast accept SHALL load all 16 channels on one edge and increment xfer_count by 1.
REQ-023 A rejected input (in_valid=1, in_ready=0) SHALL change no state; the source holds in_data/in_sel/in_bcast stable until accepted.
REQ-024 xfer_count SHALL increment by 1 per accept and saturate at 16'hFFFF (no wrap).
REQ-025 Per-channel state SHALL be the two states EMPTY (out_valid=0) and FULL (out_valid=1): EMPTY->FULL on load; FULL->EMPTY on drain without load; FULL->FULL on drain+load or hold.
REQ-026 in_sel SHALL be fully decoded; all 16 values are legal and there is no X/default output.

Reset
REQ-027 When rst_n=0 at a rising edge: out_valid=16'h0000, O0..O15=0, xfer_count=0.
REQ-028 Reset SHALL take priority over a simultaneous accept or drain; a word presented in the reset cycle SHALL be discarded.
REQ-029 During reset, in_ready SHALL still follow REQ-014 using the registered state; outputs SHALL be valid from the first edge with rst_n=1.

Verification
REQ-030 Routing: after reset, send 16'hA000+k with in_sel=k for k=0..15, all out_ready=0 -> out_valid=16'hFFFF, O<k>=16'hA000+k, xfer_count=16.
REQ-031 Backpressure: channel 5 FULL with out_ready[5]=0; present in_sel=5 -> in_ready=0 and O5 unchanged. Assert out_ready[5]=1 in the same cycle -> in_ready=1, O5 = new word, out_valid[5] stays 1.
REQ-032 Drain: channel 3 FULL; pulse out_ready[3] for one cycle with in_valid=0 -> out_valid[3]=0 on the next cycle, O3 retains its value.
REQ-033 Broadcast: channel 9 FULL with out_ready[9]=0; in_bcast=1, in_data=16'h5A5A -> in_ready=0. Release out_ready[9] -> accept; out_valid=16'hFFFF, all O<k>=16'h5A5A, xfer_count +1.
REQ-034 Reset mid-operation: channels FULL and in_valid=1 with rst_n=0 for one edge -> out_valid=0, all O<k>=0, xfer_count=0; the presented word is not loaded.
REQ-035 Saturation: force 65537 accepts -> xfer_count=16'hFFFF and remains there.

Source files
------------

// File: rtl/demultiplexer_16bit.sv
// Routes one DW-bit word per cycle into one of 16 holding registers (or all 16 on broadcast), one-cycle load latency.
// in_ready is combinational from the registered channel state and out_ready; a full, undrained target stalls the source.
module demultiplexer_16bit #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic [3:0]    in_sel,
  input  logic          in_bcast,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] O0,
  output logic [DW-1:0] O1,
  output logic [DW-1:0] O2,
  output logic [DW-1:0] O3,
  output logic [DW-1:0] O4,
  output logic [DW-1:0] O5,
  output logic [DW-1:0] O6,
  output logic [DW-1:0] O7,
  output logic [DW-1:0] O8,
  output logic [DW-1:0] O9,
  output logic [DW-1:0] O10,
  output logic [DW-1:0] O11,
  output logic [DW-1:0] O12,
  output logic [DW-1:0] O13,
  output logic [DW-1:0] O14,
  output logic [DW-1:0] O15,
  output logic [15:0]   out_valid,
  input  logic [15:0]   out_ready,
  output logic [15:0]   xfer_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

  ch_state_t     state [16];
  logic [DW-1:0] word  [16];
  logic [15:0]   free;
  logic [15:0]   load;
  logic          accept;

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      out_valid[k] = (state[k] == FULL);
    end
  end

  // A channel draining this cycle can be refilled on the same edge.
  assign free     = ~out_valid | out_ready;
  assign in_ready = in_bcast ? (&free) : free[in_sel];
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = 16'h0000;
    if (accept) begin
      load = in_bcast ? 16'hFFFF : (16'h0001 << in_sel);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) begin
        state[k] <= EMPTY;
        word[k]  <= '0;
      end
      xfer_count <= 16'h0000;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (load[k]) begin
          word[k]  <= in_data;
          state[k] <= FULL;
        end else if (state[k] == FULL && out_ready[k]) begin
          state[k] <= EMPTY;
        end
      end
      if (accept && xfer_count != 16'hFFFF) begin
        xfer_count <= xfer_count + 16'd1;
      end
    end
  end

  assign O0  = word[0];
  assign O1  = word[1];
  assign O2  = word[2];
  assign O3  = word[3];
  assign O4  = word[4];
  assign O5  = word[5];
  assign O6  = word[6];
  assign O7  = word[7];
  assign O8  = word[8];
  assign O9  = word[9];
  assign O10 = word[10];
  assign O11 = word[11];
  assign O12 = word[12];
  assign O13 = word[13];
  assign O14 = word[14];
  assign O15 = word[15];

endmodule

// File: tb/tb_demultiplexer_16bit.sv
// Scoreboarded bench for demultiplexer_16bit: per-channel expected-word queues, checked as each channel drains.
module tb_demultiplexer_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  in_sel;
  logic        in_bcast;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] o_arr [16];
  logic [15:0] out_valid;
  logic [15:0] out_ready;
  logic [15:0] xfer_count;

  always #5 clk = ~clk;

  demultiplexer_16bit #(.DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
    .O0(o_arr[0]),   .O1(o_arr[1]),   .O2(o_arr[2]),   .O3(o_arr[3]),
    .O4(o_arr[4]),   .O5(o_arr[5]),   .O6(o_arr[6]),   .O7(o_arr[7]),
    .O8(o_arr[8]),   .O9(o_arr[9]),   .O10(o_arr[10]), .O11(o_arr[11]),
    .O12(o_arr[12]), .O13(o_arr[13]), .O14(o_arr[14]), .O15(o_arr[15]),
    .out_valid(out_valid), .out_ready(out_ready), .xfer_count(xfer_count)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_valid;
  logic [15:0] m_cnt;
  logic [15:0] m_data [16];
  logic [15:0] sbq [16][$];
  bit          m_known  = 1'b0;
  bit          last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are set just after a falling edge; this checks, clocks once, updates the model, checks again.
  task automatic step();
    logic [15:0] fr;
    logic [15:0] ld;
    logic        rdy;
    logic        acc;
    #1;
    fr  = ~m_valid | out_ready;
    rdy = in_bcast ? (&fr) : fr[in_sel];
    if (m_known) chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    acc = in_valid && rdy;
    ld  = acc ? (in_bcast ? 16'hFFFF : (16'h0001 << in_sel)) : 16'h0000;
    if (rst_n) begin
      for (int k = 0; k < 16; k++) begin
        if (m_valid[k] && out_ready[k]) begin
          if (sbq[k].size() > 0) chk("drain_word", {16'd0, o_arr[k]}, {16'd0, sbq[k].pop_front()});
          else chk("sb_depth", sbq[k].size(), 1);
        end
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 16'h0000;
      m_cnt   = 16'h0000;
      for (int k = 0; k < 16; k++) begin
        m_data[k] = 16'h0000;
        sbq[k].delete();
      end
      m_known  = 1'b1;
      last_acc = 1'b0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (ld[k]) begin
          m_data[k]  = in_data;
          m_valid[k] = 1'b1;
          sbq[k].push_back(in_data);
        end else if (out_ready[k]) begin
          m_valid[k] = 1'b0;
        end
      end
      if (acc && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      last_acc = acc;
    end
    @(negedge clk);
    chk("out_valid", {16'd0, out_valid}, {16'd0, m_valid});
    chk("xfer_count", {16'd0, xfer_count}, {16'd0, m_cnt});
  endtask

  task automatic chk_words(input string tag);
    for (int k = 0; k < 16; k++) chk(tag, {16'd0, o_arr[k]}, {16'd0, m_data[k]});
  endtask

  initial begin
    m_valid   = 16'h0000;
    m_cnt     = 16'h0000;
    rst_n     = 1'b0;
    in_data   = 16'h0000;
    in_sel    = 4'd0;
    in_bcast  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 16'h0000;
    for (int k = 0; k < 16; k++) m_data[k] = 16'h0000;
    @(negedge clk);
    step();
    step();
    for (int k = 0; k < 16; k++) chk("reset_word", {16'd0, o_arr[k]}, 32'h0);
    chk("reset_valid", {16'd0, out_valid}, 32'h0);
    rst_n = 1'b1;

    // Sinks asserting ready on empty channels must change nothing.
    out_ready = 16'hFFFF;
    step();
    chk("ready_on_empty", {16'd0, out_valid}, 32'h0);
    out_ready = 16'h0000;

    // Route a distinct word to each channel.
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_sel   = 4'(k);
      in_data  = 16'hA000 + 16'(k);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("route_valid", {16'd0, out_valid}, 32'hFFFF);
    chk("route_count", {16'd0, xfer_count}, 32'd16);
    for (int k = 0; k < 16; k++) chk("route_word", {16'd0, o_arr[k]}, 32'hA000 + k);

    // Backpressure on a full channel, then drain and refill on the same edge.
    in_valid = 1'b1; in_sel = 4'd5; in_data = 16'hB005;
    step();
    chk("bp_stall", {31'd0, last_acc}, 32'd0);
    chk("bp_hold", {16'd0, o_arr[5]}, 32'hA005);
    out_ready = 16'h0020;
    #1 chk("bp_release_rdy", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0; out_ready = 16'h0000;
    step();
    chk("bp_refill_word", {16'd0, o_arr[5]}, 32'hB005);
    chk("bp_refill_valid", {31'd0, out_valid[5]}, 32'd1);

    // Drain channel 3 alone; its word must persist.
    out_ready = 16'h0008;
    step();
    out_ready = 16'h0000;
    step();
    chk("drain_valid", {31'd0, out_valid[3]}, 32'd0);
    chk("drain_keep", {16'd0, o_arr[3]}, 32'hA003);

    // Broadcast stalls on channel 9 only, then loads everything.
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 16'h5A5A;
    out_ready = 16'hFDFF;
    step();
    out_ready = 16'h0000;
    step();
    chk("bcast_stall", {31'd0, last_acc}, 32'd0);
    out_ready = 16'h0200;
    step();
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = 16'h0000;
    step();
    chk("bcast_valid", {16'd0, out_valid}, 32'hFFFF);
    chk("bcast_count", {16'd0, xfer_count}, 32'd18);
    for (int k = 0; k < 16; k++) chk("bcast_word", {16'd0, o_arr[k]}, 32'h5A5A);

    // Constrained-random traffic; a rejected word is held stable until accepted.
    last_acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (last_acc || !in_valid) begin
        in_valid = 1'($urandom_range(0, 1));
        in_sel   = 4'($urandom_range(0, 15));
        in_bcast = ($urandom_range(0, 9) == 0);
        in_data  = 16'($urandom);
      end
      out_ready = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 7) == 0) out_ready = 16'hFFFF;
      step();
    end
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = 16'h0000;
    step();
    chk_words("random_word");

    // Reset mid-traffic with a word presented.
    in_bcast = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF;
    step();
    in_bcast = 1'b0; in_sel = 4'd2; in_data = 16'h1234; out_ready = 16'h0004;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 16'h0000;
    chk("rst_valid", {16'd0, out_valid}, 32'h0);
    chk("rst_count", {16'd0, xfer_count}, 32'h0);
    for (int k = 0; k < 16; k++) chk("rst_word", {16'd0, o_arr[k]}, 32'h0);

    // Saturation: 65537 accepts on a continuously drained channel.
    in_valid = 1'b1; in_sel = 4'd0; out_ready = 16'h0001;
    for (int i = 0; i < 65537; i++) begin
      in_data = 16'(i);
      step();
    end
    chk("sat_count", {16'd0, xfer_count}, 32'hFFFF);
    step();
    chk("sat_hold", {16'd0, xfer_count}, 32'hFFFF);
    in_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
